// File: rtl/io_buffer_fifo.sv
// io_buffer_fifo: first-word-fall-through FIFO carrying a {flag, data} word
// stream between a producer and a consumer with valid/ready on both sides.
// Reports occupancy, a registered almost-full watermark and supports a
// synchronous flush that empties the FIFO without clearing storage.
module io_buffer_fifo #(
  parameter int WIDTH    = 33,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_flag,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_flag,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  // Pointer width covers DEPTH entries exactly, so increments wrap naturally.
  localparam int PW = $clog2(DEPTH);
  // Count must represent 0..DEPTH inclusive.
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PINC_C  = PW'(1);

  // Storage entry layout: bit WIDTH is the flag, bits WIDTH-1:0 are data.
  logic [WIDTH:0]  mem_r [DEPTH];

  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            almost_full_r;

  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   next_count_s;
  logic [WIDTH:0]  head_s;

  // Handshake status derives only from the registered count, so there is
  // no combinational path from in_valid/out_ready to in_ready/out_valid.
  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign in_ready  = ~full_s;
  assign out_valid = ~empty_s;

  assign push_s = in_valid & ~full_s;
  assign pop_s  = out_ready & ~empty_s;

  // Next occupancy: flush wins over any push/pop, otherwise net change.
  always_comb begin
    next_count_s = count_r;
    if (flush) begin
      next_count_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   next_count_s = count_r + ONE_C;
        2'b01:   next_count_s = count_r - ONE_C;
        default: next_count_s = count_r;
      endcase
    end
  end

  // Storage write; not reset, and a word pushed alongside flush is dropped.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= {in_flag, in_data};
    end
  end

  // Pointers, occupancy and watermark; flush returns them to the reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      almost_full_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      almost_full_r <= (next_count_s >= AF_C);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PINC_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PINC_C;
      end
      count_r       <= next_count_s;
      almost_full_r <= (next_count_s >= AF_C);
    end
  end

  // Head of queue presented fall-through, forced to zero while empty so
  // stale storage never leaks onto the outputs.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (empty_s) begin
      out_flag = 1'b0;
      out_data = {WIDTH{1'b0}};
    end else begin
      out_flag = head_s[WIDTH];
      out_data = head_s[WIDTH-1:0];
    end
  end

  assign count       = count_r;
  assign almost_full = almost_full_r;

endmodule

// File: tb/tb_io_buffer_fifo.sv
// Directed self-checking bench for io_buffer_fifo (WIDTH=33, DEPTH=4).
module tb_io_buffer_fifo;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_flag;
  logic [32:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_flag;
  logic [32:0] out_data;
  logic [2:0]  count;
  logic        almost_full;

  int tests_run;
  int tests_failed;

  io_buffer_fifo #(.WIDTH(33), .DEPTH(4), .AF_LEVEL(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_flag     (in_flag),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_flag    (out_flag),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic f, input logic [32:0] d);
    in_valid = 1'b1;
    in_flag  = f;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [32:0] w;
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_flag   = 1'b0;
    in_data   = 33'h0;
    out_ready = 1'b0;

    // Reset then idle
    repeat (3) step();
    check_eq("rst_count_during", 64'(count), 64'd0);
    rst_n = 1'b1;
    step();
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_af", 64'(almost_full), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_flag", 64'(out_flag), 64'd0);

    // Fill with out_ready low
    for (int i = 0; i < 4; i++) begin
      w = 33'h1_0000_0001 + 33'(i);
      push_word(~i[0], w);
      check_eq("fill_count", 64'(count), 64'(i + 1));
      check_eq("fill_af", 64'(almost_full), (i >= 2) ? 64'd1 : 64'd0);
      if (i == 0) begin
        check_eq("fill_head_latency", 64'(out_data), 64'h1_0000_0001);
        check_eq("fill_head_flag", 64'(out_flag), 64'd1);
      end
    end
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    push_word(1'b1, 33'h1_0000_0005);
    check_eq("full_fifth_ignored", 64'(count), 64'd4);

    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_data", 64'(out_data), 64'h1_0000_0001 + 64'(i));
      check_eq("drain_flag", 64'(out_flag), (i % 2 == 0) ? 64'd1 : 64'd0);
      step();
      check_eq("drain_count", 64'(count), 64'(3 - i));
    end
    check_eq("drain_out_valid", 64'(out_valid), 64'd0);
    check_eq("drain_out_data", 64'(out_data), 64'd0);
    out_ready = 1'b0;

    // Simultaneous push/pop at count=2, pointers wrap
    push_word(1'b0, 33'h200);
    push_word(1'b1, 33'h201);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check_eq("pp_head", 64'(out_data), 64'h200 + 64'(k));
      check_eq("pp_flag", 64'(out_flag), 64'(k % 2));
      in_valid = 1'b1;
      in_flag  = ((k + 2) % 2 == 1) ? 1'b1 : 1'b0;
      in_data  = 33'h200 + 33'(k + 2);
      step();
      check_eq("pp_count", 64'(count), 64'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Full with out_ready=1: pop only, then the push goes in
    push_word(1'b0, 33'h20C);
    push_word(1'b1, 33'h20D);
    check_eq("full2_count", 64'(count), 64'd4);
    in_valid  = 1'b1;
    in_flag   = 1'b0;
    in_data   = 33'h20E;
    out_ready = 1'b1;
    step();
    check_eq("full2_pop_only", 64'(count), 64'd3);
    check_eq("full2_head", 64'(out_data), 64'h20B);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check_eq("full2_push_later", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("full2_drain", 64'(out_data), 64'h20B + 64'(k));
      step();
    end
    check_eq("full2_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush overriding push and pop
    push_word(1'b0, 33'h300);
    push_word(1'b1, 33'h301);
    push_word(1'b0, 33'h302);
    check_eq("fl_count_pre", 64'(count), 64'd3);
    check_eq("fl_af_pre", 64'(almost_full), 64'd1);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_flag   = 1'b1;
    in_data   = 33'h3FF;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("fl_count", 64'(count), 64'd0);
    check_eq("fl_out_valid", 64'(out_valid), 64'd0);
    check_eq("fl_af", 64'(almost_full), 64'd0);
    check_eq("fl_out_data", 64'(out_data), 64'd0);
    push_word(1'b0, 33'h310);
    check_eq("fl_after_count", 64'(count), 64'd1);
    check_eq("fl_after_head", 64'(out_data), 64'h310);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset mid-stream
    push_word(1'b1, 33'h400);
    push_word(1'b0, 33'h401);
    check_eq("ar_count_pre", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_out_valid", 64'(out_valid), 64'd0);
    check_eq("ar_count", 64'(count), 64'd0);
    check_eq("ar_in_ready", 64'(in_ready), 64'd1);
    check_eq("ar_out_data", 64'(out_data), 64'd0);
    #1;
    rst_n = 1'b1;
    push_word(1'b1, 33'h500);
    check_eq("ar_restart_count", 64'(count), 64'd1);
    check_eq("ar_restart_head", 64'(out_data), 64'h500);
    check_eq("ar_restart_flag", 64'(out_flag), 64'd1);
    check_eq("ar_restart_af", 64'(almost_full), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
